multi_chan_accum: RTL

//  Parametrised multi-channel accumulator: per-channel running sums of input samples with add/sub/clear/dump ops.

---
 rtl/multi_chan_accum_pkg.sv | 22 ++
 rtl/multi_chan_accum_lane.sv | 54 +++++
 rtl/multi_chan_accum.sv | 119 +++++++++++
 3 files changed

// File: rtl/multi_chan_accum_pkg.sv
// rtl/multi_chan_accum_pkg.sv - shared types and helpers for the multi-channel accumulator
package multi_chan_accum_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_CLR  = 2'd2,
    OP_DUMP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Channel-index width; a single channel still needs one select bit
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_chan_accum_lane.sv
// rtl/multi_chan_accum_lane.sv - next-value and sticky saturation flag for one accumulator channel
module accum_lane
  import multi_chan_accum_pkg::*;
#(
  parameter int ACC_W    = 16,
  parameter int DATA_W   = 8,
  parameter int SATURATE = 1
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] operand,
  input  logic [ACC_W-1:0]  acc,
  input  logic              sat,
  output logic [ACC_W-1:0]  acc_nxt,
  output logic              sat_nxt
);

  // One spare MSB catches carry out of ADD and borrow out of SUB
  logic [ACC_W:0] ext;
  logic [ACC_W:0] sum;
  logic [ACC_W:0] diff;

  assign ext  = {{(ACC_W + 1 - DATA_W){1'b0}}, operand};
  assign sum  = {1'b0, acc} + ext;
  assign diff = {1'b0, acc} - ext;

  // Select the post-op value; CLR and DUMP both leave the channel empty
  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat;
    case (op)
      OP_ADD: begin
        if ((SATURATE != 0) && sum[ACC_W]) begin
          acc_nxt = '1;
          sat_nxt = 1'b1;
        end else begin
          acc_nxt = sum[ACC_W-1:0];
        end
      end
      OP_SUB: begin
        if ((SATURATE != 0) && diff[ACC_W]) begin
          acc_nxt = '0;
          sat_nxt = 1'b1;
        end else begin
          acc_nxt = diff[ACC_W-1:0];
        end
      end
      default: begin
        acc_nxt = '0;
        sat_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multi_chan_accum.sv
// rtl/multi_chan_accum.sv - N-channel add/sub/clear/dump accumulator with valid/ready dump port
module multi_chan_accum
  import multi_chan_accum_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  DATA_W   = 8,
  parameter int  ACC_W    = 16,
  parameter int  SATURATE = 1,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_sat,
  output logic              err
);

  state_e            state;
  op_e               op;
  logic              accept;
  logic              ch_ok;
  logic [ACC_W-1:0]  acc     [NUM_CH];
  logic [ACC_W-1:0]  acc_nxt [NUM_CH];
  logic [NUM_CH-1:0] sat;
  logic [NUM_CH-1:0] sat_nxt;
  logic [ACC_W-1:0]  sel_acc;
  logic              sel_sat;

  assign op       = op_e'(in_op);
  assign in_ready = (state == RUN);
  assign accept   = in_valid & in_ready;
  assign ch_ok    = (int'(in_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    accum_lane #(
      .ACC_W   (ACC_W),
      .DATA_W  (DATA_W),
      .SATURATE(SATURATE)
    ) u_lane (
      .op     (op),
      .operand(in_data),
      .acc    (acc[i]),
      .sat    (sat[i]),
      .acc_nxt(acc_nxt[i]),
      .sat_nxt(sat_nxt[i])
    );
  end

  // Pre-op value of the addressed channel, captured by DUMP; out-of-range selects read zero
  always_comb begin
    sel_acc = '0;
    sel_sat = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_ch == CH_W'(i)) begin
        sel_acc = acc[i];
        sel_sat = sat[i];
      end
    end
  end

  // Commit the lane result for the addressed channel only; invalid channels match no lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
      end
      sat <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_ch == CH_W'(i)) begin
          acc[i] <= acc_nxt[i];
          sat[i] <= sat_nxt[i];
        end
      end
    end
  end

  // Control FSM with registered dump outputs and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= accept & ~ch_ok;
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (accept && ch_ok && (op == OP_DUMP)) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= sel_acc;
            out_sat   <= sel_sat;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
